alu_seq: RTL



---
 rtl/alu_seq.sv | 138 +++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// Sequencer around the combinational ALU: accepts a command, holds the operands
// steady on the ALU for one settle cycle, captures result/flags, and presents them downstream.
module alu_seq #(
    parameter int n = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [n-1:0] in_a,
    input  logic [n-1:0] in_b,
    input  logic [2:0]   in_op,
    output logic [n-1:0] alu_a,
    output logic [n-1:0] alu_b,
    output logic [2:0]   alu_op,
    input  logic [n-1:0] alu_r,
    input  logic         alu_n,
    input  logic         alu_z,
    input  logic         alu_c,
    input  logic         alu_v,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [n-1:0] out_r,
    output logic [3:0]   out_flags,
    output logic         out_err,
    output logic [7:0]   op_count
);

    localparam logic [2:0] OP_ILLEGAL = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t state, state_nx;

    logic [n-1:0] a_p0, b_p0;
    logic [2:0]   op_p0;
    logic [n-1:0] r_p1;
    logic [3:0]   flags_p1;
    logic         err_p1;
    logic [7:0]   cnt;

    logic accept, accept_legal, accept_illegal, capture, handshake;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx       = state;
        accept         = 1'b0;
        accept_legal   = 1'b0;
        accept_illegal = 1'b0;
        capture        = 1'b0;
        handshake      = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    accept = 1'b1;
                    if (in_op == OP_ILLEGAL) begin
                        accept_illegal = 1'b1;
                        state_nx       = HOLD;
                    end else begin
                        accept_legal = 1'b1;
                        state_nx     = DRIVE;
                    end
                end
            end
            DRIVE: begin
                capture  = 1'b1;
                state_nx = HOLD;
            end
            HOLD: begin
                if (out_ready) begin
                    handshake = 1'b1;
                    state_nx  = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // stage 0: operand registers feeding the ALU (illegal ops leave them untouched)
    always_ff @(posedge clk) begin
        if (!rst) begin
            a_p0  <= '0;
            b_p0  <= '0;
            op_p0 <= '0;
        end else if (accept_legal) begin
            a_p0  <= in_a;
            b_p0  <= in_b;
            op_p0 <= in_op;
        end
    end

    // stage 1: result capture after the ALU settle cycle
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_p1     <= '0;
            flags_p1 <= '0;
            err_p1   <= 1'b0;
            cnt      <= '0;
        end else begin
            if (accept_illegal) begin
                r_p1     <= '0;
                flags_p1 <= '0;
                err_p1   <= 1'b1;
            end else if (capture) begin
                r_p1     <= alu_r;
                flags_p1 <= {alu_n, alu_z, alu_c, alu_v};
                err_p1   <= 1'b0;
            end
            if (handshake) begin
                cnt <= cnt + 8'd1;
            end
        end
    end

    // handshake outputs depend only on state, with reset forcing them low
    assign in_ready  = rst && (state == IDLE);
    assign out_valid = rst && (state == HOLD);

    assign alu_a     = a_p0;
    assign alu_b     = b_p0;
    assign alu_op    = op_p0;
    assign out_r     = r_p1;
    assign out_flags = flags_p1;
    assign out_err   = err_p1;
    assign op_count  = cnt;

endmodule
